// File: rtl/pid_ctrl_pkg.sv
// Shared definitions for the pid control slice: sequencer states and the
// default data width / latency of the pid core.
package pid_ctrl_pkg;

  localparam int PID_DW          = 16;
  localparam int PID_LATENCY_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ADC_REQ,
    ST_CORE_START,
    ST_CORE_WAIT,
    ST_DAC_OUT
  } pid_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// Sample-period timer: counts 0..PERIOD-1 while enabled and flags the last
// count of each period as the iteration tick.
module pid_tick_gen #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Disabling the loop parks the counter at zero so a re-enable always
  // yields a full period before the first tick.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/pid_loop_sequencer.sv
// Runs one closed-loop iteration per sample tick: ADC fetch, pid core launch,
// fixed-latency wait and actuator handshake, with sticky overrun/timeout flags.
module pid_loop_sequencer
  import pid_ctrl_pkg::*;
#(
  parameter int DW          = PID_DW,
  parameter int PERIOD      = 1000,
  parameter int PID_LATENCY = PID_LATENCY_DEF,
  parameter int ADC_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr_flags,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [DW-1:0] adc_data,
  output logic          core_start,
  output logic [DW-1:0] core_data_in,
  input  logic [DW-1:0] core_data_out,
  output logic          dac_valid,
  input  logic          dac_ready,
  output logic [DW-1:0] dac_data,
  output logic          busy,
  output logic          overrun,
  output logic          adc_timeout,
  output logic [7:0]    overrun_cnt,
  output logic [15:0]   iter_cnt
);

  localparam int LW = $clog2(PID_LATENCY + 1);
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(PID_LATENCY);
  localparam logic [TW-1:0] TO_LAST  = TW'(ADC_TIMEOUT - 1);

  pid_state_e    state_q;
  logic [LW-1:0] lat_q;
  logic [TW-1:0] to_q;
  logic [DW-1:0] sample_q;
  logic [DW-1:0] dac_data_q;
  logic          adc_req_q;
  logic          core_start_q;
  logic          dac_valid_q;
  logic          busy_q;
  logic          overrun_q;
  logic          adc_timeout_q;
  logic [7:0]    overrun_cnt_q;
  logic [15:0]   iter_cnt_q;

  logic tick;
  logic overrun_evt;
  logic timeout_evt;

  pid_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .tick_o(tick)
  );

  assign overrun_evt = tick && (state_q != ST_WAIT_TICK);
  assign timeout_evt = (state_q == ST_ADC_REQ) && !adc_ack && (to_q == TO_LAST);

  // Once a measurement is accepted the iteration runs to the DAC handshake
  // regardless of en, so the core is never left with an unread result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      to_q         <= '0;
      sample_q     <= '0;
      dac_data_q   <= '0;
      adc_req_q    <= 1'b0;
      core_start_q <= 1'b0;
      dac_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      iter_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            state_q   <= ST_ADC_REQ;
            adc_req_q <= 1'b1;
            busy_q    <= 1'b1;
            to_q      <= '0;
          end
        end
        ST_ADC_REQ: begin
          if (adc_ack) begin
            sample_q     <= adc_data;
            adc_req_q    <= 1'b0;
            core_start_q <= 1'b1;
            state_q      <= ST_CORE_START;
          end else if (to_q == TO_LAST) begin
            adc_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_WAIT_TICK;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        ST_CORE_START: begin
          core_start_q <= 1'b0;
          lat_q        <= LW'(1);
          state_q      <= ST_CORE_WAIT;
        end
        ST_CORE_WAIT: begin
          // lat_q holds the cycle offset from the start pulse.
          if (lat_q == LAT_LAST) begin
            dac_data_q  <= core_data_out;
            dac_valid_q <= 1'b1;
            state_q     <= ST_DAC_OUT;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        ST_DAC_OUT: begin
          if (dac_ready) begin
            dac_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            iter_cnt_q  <= iter_cnt_q + 16'd1;
            state_q     <= ST_WAIT_TICK;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          adc_req_q    <= 1'b0;
          core_start_q <= 1'b0;
          dac_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // A fault in the same cycle as clr_flags must not be lost, so setting
  // takes priority and restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      adc_timeout_q <= 1'b0;
    end else begin
      if (overrun_evt) begin
        overrun_q     <= 1'b1;
        overrun_cnt_q <= clr_flags ? 8'd1 : sat_inc8(overrun_cnt_q);
      end else if (clr_flags) begin
        overrun_q     <= 1'b0;
        overrun_cnt_q <= '0;
      end

      if (timeout_evt) begin
        adc_timeout_q <= 1'b1;
      end else if (clr_flags) begin
        adc_timeout_q <= 1'b0;
      end
    end
  end

  assign adc_req      = adc_req_q;
  assign core_start   = core_start_q;
  assign core_data_in = sample_q;
  assign dac_valid    = dac_valid_q;
  assign dac_data     = dac_data_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign adc_timeout  = adc_timeout_q;
  assign overrun_cnt  = overrun_cnt_q;
  assign iter_cnt     = iter_cnt_q;

endmodule

// File: doc/pid_loop_sequencer.md
Name: pid_loop_sequencer

Overview:
Sequences one closed-loop iteration of the pid core per sample period.
- A programmable sample timer starts each iteration.
- Each iteration fetches a measurement over an ADC request/acknowledge handshake, launches the pid core with a one-cycle start pulse, and waits the core's fixed latency.
- The result is handed to the actuator over a valid/ready handshake.
- It sits between the pid core and the converter interfaces, and reports overrun/timeout faults to the status register block.

Parameters:
- DW, 16, sample/result data width (matches pid core).
- PERIOD, 1000, sample period in clk cycles (>= 2*PID_LATENCY + ADC_TIMEOUT + 8).
- PID_LATENCY, 6, cycles from core_start cycle to core_data_out valid.
- ADC_TIMEOUT, 64, max cycles adc_req may stay high without adc_ack.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  loop enable.
- clr_flags  in  1  one-cycle clear of sticky fault flags and counters.
- adc_req  out  1  measurement request (level).
- adc_ack  in  1  measurement valid; adc_data captured on a cycle with adc_req&&adc_ack.
- adc_data  in  DW  measurement.
- core_start  out  1  pid core start pulse.
- core_data_in  out  DW  sample presented to core.
- core_data_out  in  DW  core result.
- dac_valid  out  1  actuator data valid.
- dac_ready  in  1  actuator accepts.
- dac_data  out  DW  actuator value.
- busy  out  1  high in any state other than IDLE/WAIT_TICK.
- overrun  out  1  sticky: tick arrived while busy.
- adc_timeout  out  1  sticky: ADC handshake timed out.
- overrun_cnt  out  8  saturating overrun count.
- iter_cnt  out  16  completed iterations, wraps at 65535->0.

Behaviour:
- Reset (async): state IDLE; all outputs 0; timer, latency and timeout counters 0; latched sample 0.
- Timer: counts 0..PERIOD-1 while en=1, wrapping to 0; tick is asserted when count==PERIOD-1. While en=0 the timer is held at 0 and no ticks occur.
- States: IDLE, WAIT_TICK, ADC_REQ, CORE_START, CORE_WAIT, DAC_OUT.
- IDLE: en=1 -> WAIT_TICK.
- WAIT_TICK: en=0 -> IDLE. Else tick -> ADC_REQ.
- ADC_REQ: adc_req=1.
  - adc_ack=1 -> latch adc_data, go to CORE_START.
  - Timeout counter reaches ADC_TIMEOUT without ack -> set adc_timeout, drop adc_req, go to WAIT_TICK; no core launch, no DAC write.
- CORE_START: core_start=1 for exactly this cycle (cycle S). core_data_in = latched sample, held stable from S until the next latch.
- CORE_WAIT: count cycles. In cycle S+PID_LATENCY, load core_data_out into dac_data at the cycle end, then go to DAC_OUT. dac_valid is high from S+PID_LATENCY+1.
- DAC_OUT: dac_valid=1 and dac_data stable until a cycle with dac_ready=1. At that edge: dac_valid->0, iter_cnt+1, go to WAIT_TICK. dac_data retains its value afterwards.
- en only takes effect in WAIT_TICK/IDLE. A started iteration always completes through the DAC handshake, so the core is never abandoned mid-run.
- Tick in any state other than WAIT_TICK:
  - The tick is dropped.
  - overrun set.
  - overrun_cnt incremented, saturating at 255.
- clr_flags clears overrun, adc_timeout and overrun_cnt. If a set event and clr_flags occur in the same cycle, the set wins (flag=1, cnt=1).
- Minimum tick-to-dac_valid latency with adc_ack immediately at ADC_REQ: tick at T -> adc_req T+1 -> core_start T+2 -> dac_valid T+3+PID_LATENCY.
- adc_ack outside ADC_REQ is ignored. dac_ready while dac_valid=0 is ignored.

Decomposition:
- Package pid_ctrl_pkg holds the state enum and default constants (DW, PID_LATENCY), shared with the pid core wrapper.
- One sub-module: pid_tick_gen (period counter, en hold, tick output).

Test Plan:
- PERIOD=40, ack immediate, dac_ready tied 1, core model returns 0x1234: tick at T gives core_start at T+2 and dac_valid at T+9 with dac_data=0x1234; iter_cnt=1.
- adc_ack never asserted, ADC_TIMEOUT=8: adc_req high 8 cycles then low; adc_timeout=1; core_start never pulses; next tick retries.
- dac_ready held 0 for 50 cycles with PERIOD=40: dac_valid and dac_data stable; overrun=1, overrun_cnt=1; after ready, iter_cnt=1.
- clr_flags in the same cycle as a new overrun tick: overrun stays 1 and overrun_cnt=1. clr_flags alone -> both 0.
- en dropped during CORE_WAIT: iteration completes with one DAC transfer, then state IDLE, no further adc_req. rst asserted mid-CORE_WAIT: all outputs 0 immediately.
- 300 overruns forced: overrun_cnt saturates at 255. iter_cnt preloaded near 65535 wraps to 0.
